hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 29 ++
 rtl/hazard_ctrl_md_busy_counter.sv | 26 ++
 rtl/hazard_ctrl.sv | 69 ++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants, scoreboard slot type and compare helpers for the
// decode-stage hazard controller.
package hazard_ctrl_pkg;

  localparam logic [1:0] TUSE_NONE      = 2'd3;
  localparam int         MD_CNT_W       = 4;
  localparam logic [3:0] MD_MULT_CYCLES = 4'd5;
  localparam logic [3:0] MD_DIV_CYCLES  = 4'd10;

  typedef struct packed {
    logic [4:0] wr;
    logic [1:0] tnew;
  } sb_slot_t;

  localparam sb_slot_t SLOT_BUBBLE = '{wr: 5'd0, tnew: 2'd0};

  // A slot blocks a source when it will write that register later than D needs it.
  // TUSE_NONE is the largest 2-bit value, so an unused source can never match.
  function automatic logic slot_hazard(input sb_slot_t slot,
                                       input logic [4:0] addr,
                                       input logic [1:0] tuse);
    return (slot.wr == addr) && (slot.tnew > tuse);
  endfunction

  function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
    return (tnew == 2'd0) ? 2'd0 : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Occupancy counter for the HI/LO multiply/divide unit; busy while nonzero.
module md_busy_counter
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  logic [MD_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= is_div ? MD_DIV_CYCLES : MD_MULT_CYCLES;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage stall controller: two-slot Tnew/Tuse scoreboard plus HI/LO busy interlock.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs_addr,
  input  logic [4:0] D_rt_addr,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_wr_addr,
  input  logic [1:0] D_Tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic       F_En,
  output logic       D_En,
  output logic       E_Empty,
  output logic       md_busy
);

  sb_slot_t e_slot;
  sb_slot_t m_slot;
  logic     rs_hazard;
  logic     rt_hazard;
  logic     md_hazard;
  logic     md_start_ok;

  always_comb begin
    rs_hazard = (D_rs_addr != 5'd0) &&
                (slot_hazard(e_slot, D_rs_addr, D_Tuse_rs) ||
                 slot_hazard(m_slot, D_rs_addr, D_Tuse_rs));
    rt_hazard = (D_rt_addr != 5'd0) &&
                (slot_hazard(e_slot, D_rt_addr, D_Tuse_rt) ||
                 slot_hazard(m_slot, D_rt_addr, D_Tuse_rt));
    md_hazard = D_md_use && md_busy;
  end

  assign stall       = rs_hazard || rt_hazard || md_hazard;
  assign F_En        = !stall;
  assign D_En        = !stall;
  assign E_Empty     = stall;
  assign md_start_ok = D_md_start && !stall;

  // A stalled D instruction enters E as a bubble so it cannot be counted twice.
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_slot <= SLOT_BUBBLE;
      m_slot <= SLOT_BUBBLE;
    end else begin
      m_slot <= '{wr: e_slot.wr, tnew: tnew_dec(e_slot.tnew)};
      if (stall) begin
        e_slot <= SLOT_BUBBLE;
      end else begin
        e_slot <= '{wr: D_wr_addr, tnew: D_Tnew};
      end
    end
  end

  md_busy_counter u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start_ok),
    .is_div (D_md_div),
    .busy   (md_busy)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue scoreboard and an independent monitor.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs_addr;
  logic [4:0] D_rt_addr;
  logic [1:0] D_Tuse_rs;
  logic [1:0] D_Tuse_rt;
  logic [4:0] D_wr_addr;
  logic [1:0] D_Tnew;
  logic       D_md_start;
  logic       D_md_div;
  logic       D_md_use;
  logic       stall;
  logic       F_En;
  logic       D_En;
  logic       E_Empty;
  logic       md_busy;

  typedef struct {
    logic  stall;
    logic  busy;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs_addr  (D_rs_addr),
    .D_rt_addr  (D_rt_addr),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .D_wr_addr  (D_wr_addr),
    .D_Tnew     (D_Tnew),
    .D_md_start (D_md_start),
    .D_md_div   (D_md_div),
    .D_md_use   (D_md_use),
    .stall      (stall),
    .F_En       (F_En),
    .D_En       (D_En),
    .E_Empty    (E_Empty),
    .md_busy    (md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkBit(input string name, input string sig, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%b required=%b", name, sig, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkBit(e.name, "stall",   stall,   e.stall);
    checkBit(e.name, "F_En",    F_En,    !e.stall);
    checkBit(e.name, "D_En",    D_En,    !e.stall);
    checkBit(e.name, "E_Empty", E_Empty, e.stall);
    checkBit(e.name, "md_busy", md_busy, e.busy);
  endtask

  // Monitor: every mid-cycle with a pending expectation is one DUT response.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  task automatic applyStimulus(input logic rst,
                               input logic [4:0] rs, input logic [1:0] tuse_rs,
                               input logic [4:0] rt, input logic [1:0] tuse_rt,
                               input logic [4:0] wr, input logic [1:0] tnew,
                               input logic md_start, input logic md_div, input logic md_use,
                               input logic exp_stall, input logic exp_busy,
                               input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst;
    D_rs_addr  = rs;
    D_Tuse_rs  = tuse_rs;
    D_rt_addr  = rt;
    D_Tuse_rt  = tuse_rt;
    D_wr_addr  = wr;
    D_Tnew     = tnew;
    D_md_start = md_start;
    D_md_div   = md_div;
    D_md_use   = md_use;
    e.stall = exp_stall;
    e.busy  = exp_busy;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  task automatic issueNop(input logic exp_busy, input string name);
    applyStimulus(1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_busy, name);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    D_rs_addr  = '0;
    D_rt_addr  = '0;
    D_Tuse_rs  = 2'd3;
    D_Tuse_rt  = 2'd3;
    D_wr_addr  = '0;
    D_Tnew     = '0;
    D_md_start = 1'b0;
    D_md_div   = 1'b0;
    D_md_use   = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] reset released");

    issueNop(1'b0, "reset_state");

    // Load-use: lw $8 with Tnew 2, consumer needs rs at Tuse 0.
    applyStimulus(1, 0, 3, 0, 3, 8, 2, 0, 0, 0, 0, 0, "lw_issue");
    applyStimulus(1, 8, 0, 0, 3, 10, 1, 0, 0, 0, 1, 0, "load_use_1");
    applyStimulus(1, 8, 0, 0, 3, 10, 1, 0, 0, 0, 1, 0, "load_use_2");
    applyStimulus(1, 8, 0, 0, 3, 10, 1, 0, 0, 0, 0, 0, "load_use_release");

    // ALU result forwarded to an rt consumer at Tuse 1.
    applyStimulus(1, 0, 3, 0, 3, 9, 1, 0, 0, 0, 0, 0, "alu_issue");
    applyStimulus(1, 0, 3, 9, 1, 0, 0, 0, 0, 0, 0, 0, "alu_forward_1");
    applyStimulus(1, 0, 3, 9, 1, 0, 0, 0, 0, 0, 0, 0, "alu_forward_2");

    // rt consumer at Tuse 0 does stall one cycle.
    applyStimulus(1, 0, 3, 0, 3, 9, 1, 0, 0, 0, 0, 0, "rt_src_issue");
    applyStimulus(1, 0, 3, 9, 0, 0, 0, 0, 0, 0, 1, 0, "rt_hazard");
    applyStimulus(1, 0, 3, 9, 0, 0, 0, 0, 0, 0, 0, 0, "rt_release");

    // Register 0 in the E slot never blocks.
    applyStimulus(1, 0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0, "zero_wr_issue");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "zero_reg");

    // Unused sources (Tuse 3) never block.
    applyStimulus(1, 0, 3, 0, 3, 12, 2, 0, 0, 0, 0, 0, "tuse_none_issue");
    applyStimulus(1, 12, 3, 12, 3, 0, 0, 0, 0, 0, 0, 0, "tuse_none");

    // Hazard from the M slot after one cycle of aging.
    applyStimulus(1, 0, 3, 0, 3, 13, 3, 0, 0, 0, 0, 0, "m_slot_issue");
    issueNop(1'b0, "m_slot_age");
    applyStimulus(1, 13, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, "m_slot_hazard");
    applyStimulus(1, 13, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, "m_slot_release");

    // Tnew 0 must saturate rather than wrap when aged into M.
    applyStimulus(1, 0, 3, 0, 3, 14, 0, 0, 0, 0, 0, 0, "sat_issue");
    applyStimulus(1, 14, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, "sat_e");
    applyStimulus(1, 14, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, "sat_m");

    // Divide followed by mflo: ten busy cycles then release.
    applyStimulus(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0, "div_issue");
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 1, 1, $sformatf("mflo_wait_%0d", i));
    applyStimulus(1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0, "mflo_release");

    // Divide then multiply two cycles later: mult held until idle, then loads 5.
    applyStimulus(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0, "div2_issue");
    issueNop(1'b1, "div2_gap_1");
    issueNop(1'b1, "div2_gap_2");
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 0, 3, 0, 3, 0, 0, 1, 0, 1, 1, 1, $sformatf("mult_wait_%0d", i));
    applyStimulus(1, 0, 3, 0, 3, 0, 0, 1, 0, 1, 0, 0, "mult_accept");
    for (int i = 0; i < 5; i++)
      issueNop(1'b1, $sformatf("mult_busy_%0d", i));
    issueNop(1'b0, "mult_done");

    // Reset at counter 6 with a live E slot aborts everything.
    applyStimulus(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0, "div3_issue");
    for (int i = 0; i < 3; i++)
      issueNop(1'b1, $sformatf("div3_count_%0d", i));
    applyStimulus(1, 0, 3, 0, 3, 15, 2, 0, 0, 0, 0, 1, "div3_load_issue");
    applyStimulus(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 1, "mid_reset");
    applyStimulus(1, 15, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, "after_reset");
    issueNop(1'b0, "after_reset_idle");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
